sata_link_tx_framer: RTL and testbench

SATA_LINK_TX_FRAMER -- requirements
Module: sata_link_tx_framer

---
 rtl/sata_link_pkg.sv | 19 +
 rtl/sata_crc32_step.sv | 20 ++
 rtl/sata_link_tx_framer.sv | 122 ++++++++++++
 tb/tb_sata_link_tx_framer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_link_pkg.sv
// Shared constants and types for the SATA link-layer transmit path.
package sata_link_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SCRAM_W = 16;

  localparam logic [DATA_W-1:0]  CRC_POLY   = 32'h04C11DB7;
  localparam logic [DATA_W-1:0]  CRC_INIT   = 32'h52325032;
  localparam logic [SCRAM_W-1:0] SCRAM_SEED = 16'hFFFF;
  // Galois feedback mask for x^16+x^15+x^13+x^4+1 (x^16 is the shift-out).
  localparam logic [SCRAM_W-1:0] SCRAM_TAPS = 16'hA011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } sata_tx_state_t;

endpackage

// File: rtl/sata_crc32_step.sv
// One-clock CRC-32 update over a full 32-bit word, MSB first, non-reflected.
module sata_crc32_step
  import sata_link_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] crc,
  output logic [DATA_W-1:0] crc_next
);

  always_comb begin
    logic [DATA_W-1:0] c;
    c = crc;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      if (c[DATA_W-1] ^ data[i]) c = (c << 1) ^ CRC_POLY;
      else                       c = c << 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/sata_link_tx_framer.sv
// Link-layer TX framer: reads payload from a show-ahead FIFO, appends CRC-32,
// scrambles every word and hands it downstream through a one-word output register.
module sata_link_tx_framer
  import sata_link_pkg::*;
(
  input  logic              reset,
  input  logic              clk,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_eop,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] tx_dat,
  output logic              tx_val,
  output logic              tx_eop,
  input  logic              tx_rdy,
  output logic              stat_frame_sent,
  output logic              stat_underrun
);

  sata_tx_state_t     state, state_next;
  logic [DATA_W-1:0]  crc, crc_step;
  logic [SCRAM_W-1:0] lfsr, lfsr_step;
  logic [DATA_W-1:0]  scram_word;
  logic               slot_free;
  logic               start, load_data, load_crc, underrun_c;

  assign slot_free = !tx_val || tx_rdy;

  sata_crc32_step u_crc (
    .data     (fifo_data),
    .crc      (crc),
    .crc_next (crc_step)
  );

  // Scrambler word: 32 serial LFSR steps, first output bit lands in bit 0.
  always_comb begin
    logic [SCRAM_W-1:0] s;
    s          = lfsr;
    scram_word = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      scram_word[i] = s[SCRAM_W-1];
      s = s[SCRAM_W-1] ? ((s << 1) ^ SCRAM_TAPS) : (s << 1);
    end
    lfsr_step = s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_rdreq = 1'b0;
    start      = 1'b0;
    load_data  = 1'b0;
    load_crc   = 1'b0;
    underrun_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          start      = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (slot_free) begin
          if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            load_data  = 1'b1;
            if (fifo_eop) state_next = CRC;
          end else begin
            underrun_c = 1'b1;
          end
        end
      end
      CRC: begin
        if (slot_free) begin
          load_crc   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register, running CRC and scrambler state; output holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_dat          <= '0;
      tx_val          <= 1'b0;
      tx_eop          <= 1'b0;
      crc             <= CRC_INIT;
      lfsr            <= SCRAM_SEED;
      stat_frame_sent <= 1'b0;
      stat_underrun   <= 1'b0;
    end else begin
      stat_frame_sent <= tx_val && tx_rdy && tx_eop;
      stat_underrun   <= underrun_c;
      if (start) begin
        crc  <= CRC_INIT;
        lfsr <= SCRAM_SEED;
      end
      if (load_data) begin
        crc    <= crc_step;
        tx_dat <= fifo_data ^ scram_word;
        tx_val <= 1'b1;
        tx_eop <= 1'b0;
        lfsr   <= lfsr_step;
      end else if (load_crc) begin
        tx_dat <= crc ^ scram_word;
        tx_val <= 1'b1;
        tx_eop <= 1'b1;
        lfsr   <= lfsr_step;
      end else if (slot_free) begin
        tx_val <= 1'b0;
        tx_eop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sata_link_tx_framer.sv
// Self-checking bench for sata_link_tx_framer: frame-level expected-word model,
// per-cycle protocol checks and an independent descramble/CRC-residue receiver.
`timescale 1ns/1ps
module tb_sata_link_tx_framer;

  logic        reset, clk;
  logic [31:0] fifo_data;
  logic        fifo_eop, fifo_empty, fifo_rdreq;
  logic [31:0] tx_dat;
  logic        tx_val, tx_eop, tx_rdy;
  logic        stat_frame_sent, stat_underrun;

  sata_link_tx_framer dut (
    .reset           (reset),
    .clk             (clk),
    .fifo_data       (fifo_data),
    .fifo_eop        (fifo_eop),
    .fifo_empty      (fifo_empty),
    .fifo_rdreq      (fifo_rdreq),
    .tx_dat          (tx_dat),
    .tx_val          (tx_val),
    .tx_eop          (tx_eop),
    .tx_rdy          (tx_rdy),
    .stat_frame_sent (stat_frame_sent),
    .stat_underrun   (stat_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic straight from the polynomial definitions.
  function automatic logic [31:0] scr_word(input int k);
    logic [15:0] s;
    logic [31:0] w;
    s = 16'hFFFF;
    w = '0;
    for (int j = 0; j <= k; j++)
      for (int b = 0; b < 32; b++) begin
        w[b] = s[15];
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'hA011 : 16'h0000);
      end
    return w;
  endfunction

  function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [31:0] w);
    for (int b = 31; b >= 0; b--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ w[b]) ? 32'h04C11DB7 : 32'h0);
    return c;
  endfunction

  // Show-ahead FIFO
  logic [31:0] mem_dat [0:255];
  logic        mem_eop [0:255];
  int          wr_idx, rd_idx;
  logic        gate;

  assign fifo_empty = gate || (rd_idx == wr_idx);
  assign fifo_data  = mem_dat[rd_idx];
  assign fifo_eop   = mem_eop[rd_idx];

  always @(posedge clk) begin
    if (reset)           rd_idx <= wr_idx;
    else if (fifo_rdreq) rd_idx <= rd_idx + 1;
  end

  typedef struct packed { logic [31:0] dat; logic eop; } exp_t;
  exp_t exp_q[$];

  task automatic send_frame(input int n, input logic [31:0] seed);
    logic [31:0] c, w;
    c = 32'h52325032;
    for (int i = 0; i < n; i++) begin
      w = seed + 32'(i) * 32'h9E3779B9;
      mem_dat[wr_idx] = w;
      mem_eop[wr_idx] = (i == n - 1);
      c = crc_add(c, w);
      exp_q.push_back('{dat: w ^ scr_word(i), eop: 1'b0});
      wr_idx++;
    end
    exp_q.push_back('{dat: c ^ scr_word(n), eop: 1'b1});
  endtask

  // Per-test statistics, stepped by the monitor.
  int t_val, t_gap_run, t_gap_max, t_under, t_sent, t_rd, t_xfer;
  logic t_seen;
  logic [31:0] t_first, t_last;

  task automatic clear_stats();
    t_val = 0; t_gap_run = 0; t_gap_max = 0; t_under = 0; t_sent = 0;
    t_rd = 0; t_xfer = 0; t_seen = 1'b0; t_first = '0; t_last = '0;
  endtask

  logic        p_val, p_rdy, p_eop, p_rd, p_eopx;
  logic [31:0] p_dat;
  int          rx_idx;
  logic [31:0] rx_crc;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      p_val = 0; p_rdy = 0; p_eop = 0; p_rd = 0; p_eopx = 0; p_dat = '0;
      rx_idx = 0; rx_crc = 32'h52325032;
    end else begin
      if (p_val && !p_rdy) begin
        chk("hold_val", 32'(tx_val), 32'd1);
        chk("hold_dat", tx_dat, p_dat);
        chk("hold_eop", 32'(tx_eop), 32'(p_eop));
      end
      if (p_rd) begin
        chk("latency_val", 32'(tx_val), 32'd1);
        chk("latency_eop", 32'(tx_eop), 32'd0);
      end
      chk("frame_sent", 32'(stat_frame_sent), 32'(p_eopx));
      if (tx_val && !tx_rdy) chk("stall_rdreq", 32'(fifo_rdreq), 32'd0);
      if (fifo_empty)        chk("empty_rdreq", 32'(fifo_rdreq), 32'd0);
      if (tx_val && tx_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", tx_dat, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          chk("word_dat", tx_dat, e.dat);
          chk("word_eop", 32'(tx_eop), 32'(e.eop));
        end
        rx_crc = crc_add(rx_crc, tx_dat ^ scr_word(rx_idx));
        rx_idx++;
        if (tx_eop) begin
          chk("rx_crc_residue", rx_crc, 32'h0);
          rx_idx = 0;
          rx_crc = 32'h52325032;
        end
        if (t_xfer == 0) t_first = tx_dat;
        t_last = tx_dat;
        t_xfer++;
      end
      if (tx_val) begin
        if (t_seen && t_gap_run > t_gap_max) t_gap_max = t_gap_run;
        t_gap_run = 0;
        t_seen = 1'b1;
        t_val++;
      end else if (t_seen) begin
        t_gap_run++;
      end
      if (stat_underrun)   t_under++;
      if (stat_frame_sent) t_sent++;
      if (fifo_rdreq)      t_rd++;
      p_val = tx_val; p_rdy = tx_rdy; p_eop = tx_eop; p_dat = tx_dat;
      p_rd = fifo_rdreq; p_eopx = tx_val && tx_rdy && tx_eop;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_idx != wr_idx || tx_val) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic wait_xfer(input int k, input string name);
    int n;
    n = 0;
    while (t_xfer < k && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 32'(t_xfer), 32'(k));
  endtask

  initial begin
    logic [7:0] pat;
    int base;
    checks = 0; errors = 0;
    wr_idx = 0; gate = 1'b0; tx_rdy = 1'b1; reset = 1'b1;
    clear_stats();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_val", 32'(tx_val), 32'd0);
    chk("rst_eop", 32'(tx_eop), 32'd0);
    chk("rst_dat", tx_dat, 32'h0);
    chk("rst_sent", 32'(stat_frame_sent), 32'd0);
    chk("rst_under", 32'(stat_underrun), 32'd0);
    chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Model pins
    chk("model_scr0", scr_word(0), 32'hC2D2768D);
    chk("model_crc_residue", crc_add(crc_add(32'h52325032, 32'h12345678),
                                     crc_add(32'h52325032, 32'h12345678)), 32'h0);

    // Single zero word
    clear_stats();
    send_frame(1, 32'h0);
    chk("idle_no_rdreq", 32'(fifo_rdreq), 32'd0);
    wait_done("single");
    chk("single_rd_cycles", 32'(t_rd), 32'd1);
    chk("single_first", t_first, 32'hC2D2768D);
    chk("single_crc_word", t_last, crc_add(32'h52325032, 32'h0) ^ scr_word(1));
    chk("single_xfers", 32'(t_xfer), 32'd2);
    chk("single_sent", 32'(t_sent), 32'd1);
    chk("single_under", 32'(t_under), 32'd0);

    // Eight back-to-back 4-word frames
    clear_stats();
    for (int f = 0; f < 8; f++) send_frame(4, 32'hA5000000 + 32'(f) * 32'h01010101);
    wait_done("b2b");
    chk("b2b_val_cycles", 32'(t_val), 32'd40);
    chk("b2b_gap_le1", 32'(t_gap_max <= 1), 32'd1);
    chk("b2b_sent", 32'(t_sent), 32'd8);
    chk("b2b_under", 32'(t_under), 32'd0);

    // Five-clock stall mid-frame
    clear_stats();
    send_frame(5, 32'h13572468);
    wait_xfer(2, "stall");
    tx_rdy = 1'b0;
    repeat (5) step();
    tx_rdy = 1'b1;
    wait_done("stall");
    chk("stall_xfers", 32'(t_xfer), 32'd6);
    chk("stall_sent", 32'(t_sent), 32'd1);

    // FIFO empty three clocks after word 2 of 5
    clear_stats();
    base = wr_idx;
    send_frame(5, 32'hDEADBEEF);
    begin
      int n;
      n = 0;
      while (rd_idx != base + 2 && n < 100) begin step(); n++; end
      if (n >= 100) chk("underrun_timeout", 32'(rd_idx), 32'(base + 2));
    end
    gate = 1'b1;
    repeat (3) step();
    gate = 1'b0;
    wait_done("underrun");
    chk("underrun_pulses", 32'(t_under), 32'd3);
    chk("underrun_xfers", 32'(t_xfer), 32'd6);
    chk("underrun_sent", 32'(t_sent), 32'd1);

    // Reset after word 2 of 4, then resend
    clear_stats();
    send_frame(4, 32'h0BADF00D);
    wait_xfer(2, "rst_mid");
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_val", 32'(tx_val), 32'd0);
    chk("rst_mid_sent", 32'(stat_frame_sent), 32'd0);
    step();
    reset = 1'b0;
    clear_stats();
    repeat (6) step();
    chk("rst_mid_no_crc", 32'(t_xfer), 32'd0);
    send_frame(4, 32'h0BADF00D);
    wait_done("rst_resend");
    chk("rst_resend_first", t_first, 32'h0BADF00D ^ scr_word(0));
    chk("rst_resend_xfers", 32'(t_xfer), 32'd5);
    chk("rst_resend_sent", 32'(t_sent), 32'd1);

    // Irregular downstream ready
    clear_stats();
    pat = 8'b0110_1101;
    send_frame(3, 32'h77665544);
    for (int i = 0; i < 16; i++) begin
      tx_rdy = pat[i % 8];
      step();
    end
    tx_rdy = 1'b1;
    wait_done("rdy_pat");
    chk("rdy_pat_xfers", 32'(t_xfer), 32'd4);
    chk("rdy_pat_sent", 32'(t_sent), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
